// File: rtl/corep.sv
// rtl/corep.sv - core-wide PR and free-list types and sizing constants
package corep;

    localparam int PRF_BANK_COUNT                = 4;
    localparam int LOG_PRF_BANK_COUNT            = 2;
    localparam int PR_WIDTH                      = 7;
    localparam int UPPER_PR_WIDTH                = PR_WIDTH - LOG_PRF_BANK_COUNT;

    localparam int FREE_LIST_LENGTH_PER_BANK     = 32;
    localparam int LOG_FREE_LIST_LENGTH_PER_BANK = 5;
    localparam int FREE_LIST_LOWER_THRESHOLD     = 8;
    localparam int FREE_LIST_UPPER_THRESHOLD     = 24;

    typedef logic [PR_WIDTH-1:0]                      PR_t;
    typedef logic [UPPER_PR_WIDTH-1:0]                upper_PR_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0]            PR_bank_t;
    typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] FL_ptr_t;
    typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0]   FL_cnt_t;

endpackage

// File: rtl/free_list_bank.sv
// rtl/free_list_bank.sv - one PRF bank's circular free-PR FIFO; optional
// empty-list bypass selected by FREE_LIST_BYPASS_EN
module free_list_bank
    import corep::*;
#(
    parameter int BANK   = 0,
    parameter int LENGTH = FREE_LIST_LENGTH_PER_BANK
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      enq_valid,
    input  upper_PR_t enq_upper_PR,
    output logic      deq_valid,
    output PR_t       deq_PR,
    input  logic      deq_ready,
    output logic      below_lower,
    output logic      above_upper,
    output logic      overflow_err
);

    // After reset this bank owns upper PRs 16..31; 0..15 are architectural.
    localparam int RESET_FILL = 16;

    localparam PR_bank_t BANK_BITS = PR_bank_t'(BANK);
    localparam FL_ptr_t  LAST_PTR  = FL_ptr_t'(LENGTH - 1);
    localparam FL_cnt_t  FULL_CNT  = FL_cnt_t'(LENGTH);
    localparam FL_cnt_t  LOWER_CNT = FL_cnt_t'(FREE_LIST_LOWER_THRESHOLD);
    localparam FL_cnt_t  UPPER_CNT = FL_cnt_t'(FREE_LIST_UPPER_THRESHOLD);

    upper_PR_t entries [0:LENGTH-1];
    FL_ptr_t   head;
    FL_ptr_t   tail;
    FL_cnt_t   count;

    logic      empty;
    logic      full;
    logic      bypass;
    logic      deq_fire;
    logic      bypass_fire;
    logic      enq_write;
    logic      enq_drop;
    logic      head_adv;
    FL_cnt_t   count_next;
    FL_ptr_t   head_inc;
    FL_ptr_t   tail_inc;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = empty && enq_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        deq_valid = !empty || bypass;
        deq_PR    = bypass ? {enq_upper_PR, BANK_BITS} : {entries[head], BANK_BITS};
    end

    // A bypassed enq handed straight to rename never touches storage.
    assign deq_fire    = deq_valid && deq_ready;
    assign bypass_fire = bypass && deq_fire;
    assign head_adv    = deq_fire && !bypass_fire;
    assign enq_write   = enq_valid && !bypass_fire && (!full || deq_fire);
    assign enq_drop    = enq_valid && full && !deq_fire;

    assign head_inc = (head == LAST_PTR) ? '0 : head + FL_ptr_t'(1);
    assign tail_inc = (tail == LAST_PTR) ? '0 : tail + FL_ptr_t'(1);

    always_comb begin
        count_next = count;
        case ({enq_write, head_adv})
            2'b10:   count_next = count + FL_cnt_t'(1);
            2'b01:   count_next = count - FL_cnt_t'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LENGTH; i++) begin
                entries[i] <= (i < RESET_FILL) ? upper_PR_t'(i + RESET_FILL) : '0;
            end
            head         <= '0;
            tail         <= FL_ptr_t'(RESET_FILL);
            count        <= FL_cnt_t'(RESET_FILL);
            overflow_err <= 1'b0;
            below_lower  <= (FL_cnt_t'(RESET_FILL) < LOWER_CNT);
            above_upper  <= (FL_cnt_t'(RESET_FILL) > UPPER_CNT);
        end else begin
            if (enq_write) begin
                entries[tail] <= enq_upper_PR;
                tail          <= tail_inc;
            end
            if (head_adv) begin
                head <= head_inc;
            end
            if (enq_drop) begin
                overflow_err <= 1'b1;
            end
            count       <= count_next;
            below_lower <= (count_next < LOWER_CNT);
            above_upper <= (count_next > UPPER_CNT);
        end
    end

endmodule
